uart_buffer: RTL and testbench

Responder end of the CPU's io_core UART handshake (order/accepted/done). It serialises 1-4 byte words from the core onto a byte-wide TX PHY interface. It also assembles 1-4 byte words for the core from a byte-wide RX PHY stream, which is buffered in an RX FIFO so bytes arriving while the core is busy are not lost. It sits between io_core and the uart_tx/uart_rx bit-level PHYs.

---
 rtl/uart_buffer_pkg.sv | 22 ++
 rtl/uart_buffer_byte_fifo.sv | 68 ++++++
 rtl/uart_buffer.sv | 173 +++++++++++++++++
 tb/tb_uart_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_buffer_pkg.sv
// rtl/uart_buffer_pkg.sv - shared constants, state encoding and byte helper for uart_buffer
package uart_buffer_pkg;

    localparam int LEN_WORD = 32;

    localparam logic [1:0] UART_SIZE_1B = 2'd0;
    localparam logic [1:0] UART_SIZE_2B = 2'd1;
    localparam logic [1:0] UART_SIZE_3B = 2'd2;
    localparam logic [1:0] UART_SIZE_4B = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2
    } state_e;

    // Little-endian byte lane extraction: idx 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [LEN_WORD-1:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_buffer_byte_fifo.sv
// rtl/uart_buffer_byte_fifo.sv - byte-wide FIFO with registered storage, no fall-through
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_buffer.sv
// rtl/uart_buffer.sv - io_core UART responder: word-to-byte TX serialiser and FIFO-backed RX assembler
module uart_buffer
    import uart_buffer_pkg::*;
#(
    parameter int RX_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_order,
    input  logic                uart_write_flag,
    input  logic [1:0]          uart_size,
    input  logic [LEN_WORD-1:0] uart_o_data,
    output logic [LEN_WORD-1:0] uart_i_data,
    output logic                uart_accepted,
    output logic                uart_done,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_overrun
);

    localparam int CNT_W = $clog2(RX_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [LEN_WORD-1:0] o_data_q, o_data_d;
    logic [LEN_WORD-1:0] i_data_q, i_data_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                accepted_q, accepted_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                rx_push, rx_pop, rx_drop;
    logic                rx_empty, rx_full;
    logic [7:0]          rx_dout;
    logic [CNT_W-1:0]    rx_count;
    logic                tx_fire, last_byte;

    assign tx_fire   = (state_q == ST_TX) && tx_valid_q && tx_ready;
    assign rx_pop    = (state_q == ST_RX) && !rx_empty;
    assign last_byte = (cnt_q == size_q);
    assign rx_push   = rx_valid && ((rx_count < CNT_W'(RX_DEPTH)) || rx_pop);
    assign rx_drop   = rx_valid && rx_full && !rx_pop;

    byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (uart_order) begin
                    state_d = uart_write_flag ? ST_TX : ST_RX;
                end
            end
            ST_TX: begin
                if (tx_fire && last_byte) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX: begin
                if (rx_pop && last_byte) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        size_d     = size_q;
        cnt_d      = cnt_q;
        o_data_d   = o_data_q;
        i_data_d   = i_data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        accepted_d = 1'b0;
        done_d     = 1'b0;
        overrun_d  = overrun_q | rx_drop;
        case (state_q)
            ST_IDLE: begin
                if (uart_order) begin
                    size_d     = uart_size;
                    o_data_d   = uart_o_data;
                    cnt_d      = 2'd0;
                    accepted_d = 1'b1;
                    if (uart_write_flag) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = uart_o_data[7:0];
                    end else begin
                        i_data_d = '0;
                    end
                end
            end
            ST_TX: begin
                if (tx_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (last_byte) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        tx_data_d = word_byte(o_data_q, cnt_q + 2'd1);
                    end
                end
            end
            ST_RX: begin
                if (rx_pop) begin
                    i_data_d[{cnt_q, 3'b000} +: 8] = rx_dout;
                    cnt_d = cnt_q + 2'd1;
                    if (last_byte) begin
                        done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q     <= UART_SIZE_1B;
            cnt_q      <= 2'd0;
            o_data_q   <= '0;
            i_data_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            accepted_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            o_data_q   <= o_data_d;
            i_data_q   <= i_data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            accepted_q <= accepted_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign uart_i_data   = i_data_q;
    assign uart_accepted = accepted_q;
    assign uart_done     = done_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_buffer.sv
// tb/tb_uart_buffer.sv - self-checking bench for uart_buffer
module tb_uart_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_order;
    logic        uart_write_flag;
    logic [1:0]  uart_size;
    logic [31:0] uart_o_data;
    logic [31:0] uart_i_data;
    logic        uart_accepted;
    logic        uart_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overrun;

    always #5 clk = ~clk;

    uart_buffer #(.RX_DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_order      (uart_order),
        .uart_write_flag (uart_write_flag),
        .uart_size       (uart_size),
        .uart_o_data     (uart_o_data),
        .uart_i_data     (uart_i_data),
        .uart_accepted   (uart_accepted),
        .uart_done       (uart_done),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_overrun      (rx_overrun)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        order;
        logic        wf;
        logic [1:0]  size;
        logic [31:0] odata;
        logic        ready;
        logic        acc;
        logic        done;
        logic        valid;
        logic [7:0]  data;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] byte_q[$];
    logic [7:0] ovr_bytes[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        uart_order      = 1'b0;
        uart_write_flag = 1'b0;
        uart_size       = 2'd0;
        uart_o_data     = 32'h0;
        tx_ready        = 1'b0;
        rx_data         = 8'h00;
        rx_valid        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic vec_t v(input logic order, input logic wf, input logic [1:0] size,
                               input logic [31:0] odata, input logic ready, input logic acc,
                               input logic done, input logic valid, input logic [7:0] data);
        vec_t r;
        r.order = order; r.wf = wf; r.size = size; r.odata = odata; r.ready = ready;
        r.acc = acc; r.done = done; r.valid = valid; r.data = data;
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic read_word(input logic [1:0] size, input logic [31:0] exp, input int exp_cycle, input string name);
        int k;
        uart_order      = 1'b1;
        uart_write_flag = 1'b0;
        uart_size       = size;
        step();
        uart_order = 1'b0;
        check({name, " accepted"}, 32'(uart_accepted), 32'd1);
        k = 1;
        while (!uart_done && k < 100) begin
            step();
            k++;
        end
        check({name, " done"}, 32'(uart_done), 32'd1);
        if (exp_cycle > 0) check({name, " latency"}, 32'(k), 32'(exp_cycle));
        check({name, " word"}, uart_i_data, exp);
    endtask

    task automatic rand_rx();
        if (byte_q.size() < 12 && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            byte_q.push_back(rx_data);
        end else begin
            rx_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] got;
        int          nb, k;
        logic [1:0]  sz;
        logic [31:0] dat;

        do_reset();
        check("reset i_data", uart_i_data, 32'h0);
        check("reset accepted", 32'(uart_accepted), 32'd0);
        check("reset done", 32'(uart_done), 32'd0);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset overrun", 32'(rx_overrun), 32'd0);

        // TX 4 bytes
        vecs.push_back(v(1, 1, 3, 32'hDEADBEEF, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 1, 0, 1, 8'hEF));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'hBE));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'hAD));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'hDE));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 1, 0, 8'h00));
        // TX backpressure
        vecs.push_back(v(1, 1, 1, 32'h00001234, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 32'h0, 0, 1, 0, 1, 8'h34));
        vecs.push_back(v(0, 0, 0, 32'h0, 0, 0, 0, 1, 8'h34));
        vecs.push_back(v(0, 0, 0, 32'h0, 0, 0, 0, 1, 8'h34));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'h34));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'h12));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 1, 0, 8'h00));
        // TX single byte
        vecs.push_back(v(1, 1, 0, 32'h000000AB, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 1, 0, 1, 8'hAB));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 1, 0, 8'h00));
        // Orders while busy are ignored
        vecs.push_back(v(1, 1, 2, 32'h00C0FFEE, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(1, 0, 0, 32'h0, 1, 1, 0, 1, 8'hEE));
        vecs.push_back(v(1, 1, 3, 32'h11111111, 1, 0, 0, 1, 8'hFF));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 1, 8'hC0));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 1, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(v(0, 0, 0, 32'h0, 1, 0, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            uart_order      = vecs[i].order;
            uart_write_flag = vecs[i].wf;
            uart_size       = vecs[i].size;
            uart_o_data     = vecs[i].odata;
            tx_ready        = vecs[i].ready;
            check($sformatf("vec%0d accepted", i), 32'(uart_accepted), 32'(vecs[i].acc));
            check($sformatf("vec%0d done", i), 32'(uart_done), 32'(vecs[i].done));
            check($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].valid));
            if (vecs[i].valid) check($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].data));
            step();
        end
        idle_inputs();

        // RX from pre-buffered bytes
        push_byte(8'h34);
        push_byte(8'h12);
        push_byte(8'h56);
        read_word(2'd1, 32'h00001234, 3, "rx prebuf 2B");
        check("rx prebuf count", 32'(dut.rx_count), 32'd1);
        read_word(2'd0, 32'h00000056, 2, "rx prebuf 1B");
        check("rx prebuf empty", 32'(dut.rx_count), 32'd0);

        // RX stalls on empty FIFO
        uart_order = 1'b1;
        uart_size  = 2'd3;
        step();
        uart_order = 1'b0;
        check("rx stall accepted", 32'(uart_accepted), 32'd1);
        check("rx stall cleared", uart_i_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rx stall no done", 32'(uart_done), 32'd0);
        end
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        check("rx stall not yet done", 32'(uart_done), 32'd0);
        step();
        check("rx stall done", 32'(uart_done), 32'd1);
        check("rx stall word", uart_i_data, 32'h04030201);

        // Overrun on the 17th byte into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i * 7 + 3);
            ovr_bytes.push_back(rx_data);
            step();
            if (i == 15) begin
                check("ovr 16 count", 32'(dut.rx_count), 32'd16);
                check("ovr 16 flag", 32'(rx_overrun), 32'd0);
            end
        end
        rx_valid = 1'b0;
        check("ovr 17 count", 32'(dut.rx_count), 32'd16);
        check("ovr 17 flag", 32'(rx_overrun), 32'd1);
        for (int j = 0; j < 4; j++) begin
            w = {ovr_bytes[4*j+3], ovr_bytes[4*j+2], ovr_bytes[4*j+1], ovr_bytes[4*j]};
            read_word(2'd3, w, 5, $sformatf("ovr drain%0d", j));
        end
        check("ovr sticky", 32'(rx_overrun), 32'd1);

        // Reset in the middle of an RX order
        uart_order = 1'b1;
        uart_size  = 2'd3;
        step();
        uart_order = 1'b0;
        rx_valid   = 1'b1;
        rx_data    = 8'hA5;
        step();
        rx_data = 8'hB6;
        step();
        rx_valid = 1'b0;
        check("midrx pre i_data", uart_i_data, 32'h000000A5);
        check("midrx pre count", 32'(dut.rx_count), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrx rst i_data", uart_i_data, 32'h0);
        check("midrx rst overrun", 32'(rx_overrun), 32'd0);
        check("midrx rst count", 32'(dut.rx_count), 32'd0);
        check("midrx rst outs", {29'd0, uart_accepted, uart_done, tx_valid}, 32'd0);
        check("midrx rst tx_data", 32'(tx_data), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrx no done", 32'(uart_done), 32'd0);
        end

        // Randomised mix against a byte-stream model
        do_reset();
        byte_q.delete();
        for (int op = 0; op < 40; op++) begin
            sz  = 2'($urandom_range(0, 3));
            dat = $urandom;
            nb  = int'(sz) + 1;
            uart_order      = 1'b1;
            uart_write_flag = 1'($urandom_range(0, 1));
            uart_size       = sz;
            uart_o_data     = dat;
            tx_ready        = 1'($urandom_range(0, 1));
            rand_rx();
            step();
            uart_order = 1'b0;
            check("rand accepted", 32'(uart_accepted), 32'd1);
            got = 32'h0;
            k   = 0;
            while (!uart_done && k < 300) begin
                tx_ready = ($urandom_range(0, 9) < 7);
                rand_rx();
                if (tx_valid && tx_ready) begin
                    if (k < 4) got[8*k +: 8] = tx_data;
                    k++;
                end else if (!uart_write_flag) begin
                    k++;
                end
                step();
            end
            rx_valid = 1'b0;
            check("rand done", 32'(uart_done), 32'd1);
            if (uart_write_flag) begin
                check("rand tx bytes", 32'(k), 32'(nb));
                w = dat;
                if (nb < 4) w = dat & ((32'd1 << (8 * nb)) - 32'd1);
                check("rand tx word", got, w);
            end else begin
                w = 32'h0;
                for (int b = 0; b < nb; b++) w[8*b +: 8] = byte_q.pop_front();
                check("rand rx word", uart_i_data, w);
            end
        end
        check("rand no overrun", 32'(rx_overrun), 32'd0);
        check("rand fifo level", 32'(dut.rx_count), 32'(byte_q.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
